// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// The loader turns a byte stream into big-endian instruction words.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        DONE      = 2'd2,
        DONE_FULL = 2'd3
    } loader_state_e;

    localparam logic [31:0] END_MARKER_DEFAULT = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD     = 4;
    localparam int          BYTE_CNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_assembler.sv
// 8-to-32 big-endian shift register with a byte counter.
// word_valid pulses combinationally in the cycle the final byte of a word arrives.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]           shift_q, shift_d;

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        // Word as it will look once the incoming byte is shifted in.
        word       = {shift_q[23:0], data};
        word_valid = en && !clr && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (en) begin
            shift_d = word;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads instruction memory from the UART byte stream, starting at address 0,
// until END_MARKER arrives or memory is full; then reports done to the core.
module program_loader
    import loader_pkg::*;
#(
    parameter int          INST_MEM_WIDTH = 2,
    parameter logic [31:0] END_MARKER     = END_MARKER_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      wr_en,
    output logic [INST_MEM_WIDTH-1:0] wr_addr,
    output logic [31:0]               wr_data,
    output logic                      loading,
    output logic                      done,
    output logic                      overflow,
    output logic [INST_MEM_WIDTH:0]   prog_len
);

    localparam logic [INST_MEM_WIDTH-1:0] LAST_ADDR = {INST_MEM_WIDTH{1'b1}};

    loader_state_e               state_q, state_d;
    logic                        wr_en_q, wr_en_d;
    logic [INST_MEM_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]                 wr_data_q, wr_data_d;
    logic                        loading_q, loading_d;
    logic                        done_q, done_d;
    logic                        overflow_q, overflow_d;
    logic [INST_MEM_WIDTH:0]     prog_len_q, prog_len_d;

    logic        asm_clr, asm_en, word_valid;
    logic [31:0] word;
    logic        is_marker;

    byte_assembler u_asm (
        .CLK        (CLK),
        .reset      (reset),
        .clr        (asm_clr),
        .en         (asm_en),
        .data       (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign is_marker = (word == END_MARKER);

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;
        prog_len_d = prog_len_q;
        asm_clr    = 1'b0;
        asm_en     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // Bytes arriving here (including with start) are dropped.
                if (start) begin
                    state_d    = LOAD;
                    asm_clr    = 1'b1;
                    wr_addr_d  = '0;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end
            end
            LOAD: begin
                asm_en = rx_valid;
                // Address advances the cycle after its write; it never rolls over.
                if (wr_en_q && wr_addr_q != LAST_ADDR)
                    wr_addr_d = wr_addr_q + 1'b1;
                if (word_valid) begin
                    if (is_marker) begin
                        state_d = DONE;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = word;
                        prog_len_d = prog_len_q + 1'b1;
                        if (wr_addr_q == LAST_ADDR) begin
                            state_d    = DONE_FULL;
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            DONE_FULL: begin
                if (start) begin
                    state_d    = LOAD;
                    asm_clr    = 1'b1;
                    wr_addr_d  = '0;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end else begin
                    // One more word decides whether the load ended exactly at capacity.
                    asm_en = rx_valid;
                    if (word_valid) begin
                        state_d = DONE;
                        if (is_marker)
                            overflow_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        loading_d = (state_d == LOAD);
        done_d    = (state_d == DONE) || (state_d == DONE_FULL);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            prog_len_q <= prog_len_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign loading  = loading_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign prog_len = prog_len_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream neighbour of inst_fetch.
- Accepts the serial byte stream from the UART receiver and assembles it into 32-bit big-endian instruction words.
- Writes each word into the instruction memory write port at consecutive addresses starting from 0.
- Signals completion to the core so instruction fetch can begin at pc = 0.

Parameters:
- INST_MEM_WIDTH, 2: instruction memory address width; capacity is 2**INST_MEM_WIDTH words.
- END_MARKER, 32'hFFFF_FFFF: word that terminates a load; it is never written to memory.

Ports:
- CLK  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load session
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data is valid this cycle; single-cycle pulse per byte
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  INST_MEM_WIDTH  word address for the write
- wr_data  out  32  assembled instruction word
- loading  out  1  high while in LOAD
- done  out  1  load session finished; held until the next start or reset
- overflow  out  1  memory filled before END_MARKER was received
- prog_len  out  INST_MEM_WIDTH+1  number of words written

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE
  - wr_en = 0, wr_addr = 0, wr_data = 0
  - loading = 0, done = 0, overflow = 0, prog_len = 0
  - byte counter = 0, shift register = 0
- Reset has priority over every other input. Reset mid-load abandons any partial word; memory contents already written are left as they are.

States:
- IDLE:
  - start -> LOAD; clear byte counter, wr_addr, prog_len.
  - rx_valid is ignored.
- LOAD:
  - Each rx_valid cycle: shift register <= {shift[23:0], rx_data}; byte counter increments modulo 4. The first byte received becomes bits [31:24].
  - Fourth byte of a word accepted at cycle n, assembled word != END_MARKER:
    - in cycle n+1: wr_en = 1 for exactly one cycle, with wr_data = word and wr_addr = current address;
    - address and prog_len then increment.
  - Fourth byte completes END_MARKER: no write; -> DONE at n+1; done = 1.
  - Write to the last address (2**INST_MEM_WIDTH - 1): prog_len becomes 2**INST_MEM_WIDTH; -> DONE with done = 1 and overflow = 1.
    - overflow is cleared if the next 4 bytes form END_MARKER; those 4 bytes are still not written.
    - Implementation: DONE_FULL sub-state that continues assembling until a word completes.
  - start during LOAD is ignored.
- DONE / DONE_FULL:
  - done = 1.
  - start -> LOAD with fresh counters; done and overflow are cleared in the same transition.
  - In DONE, bytes are ignored.
- Simultaneous events:
  - start and rx_valid in the same cycle in IDLE/DONE: the byte is dropped.
  - rx_valid on every consecutive cycle must be sustained: the pipeline accepts one byte per cycle, and a wr_en cycle may coincide with a new byte being shifted in.
- wr_addr wraps only through a new start; it never rolls over inside a session.
- loading = (state == LOAD).

Decomposition:
- Package loader_pkg holds:
  - typedef enum of loader states: IDLE, LOAD, DONE, DONE_FULL;
  - END_MARKER default value;
  - BYTES_PER_WORD = 4.
- Sub-module byte_assembler: 8-to-32 shift register plus 2-bit counter, with a word_valid pulse output.
- program_loader owns the FSM, address and length counters, and overflow logic.

Test Plan:
- Reset, start, then bytes 00, c2, 10, 04 each as a 1-cycle rx_valid -> one cycle after the 4th byte: wr_en = 1, wr_addr = 0, wr_data = 32'h00c21004; prog_len = 1.
- Two words, then FF FF FF FF -> writes at addr 0 and 1 only; done = 1, overflow = 0, prog_len = 2; no wr_en for the marker.
- INST_MEM_WIDTH = 2, 4 words without marker -> 4 writes at addr 0..3; done = 1, overflow = 1, prog_len = 4; a 5th word produces no wr_en.
- Back-to-back bytes (rx_valid held 8 cycles) -> two wr_en pulses at cycles 5 and 9 after the first byte, with correct data.
- Reset asserted after 2 bytes, then start and 4 new bytes -> single write with only the new bytes; the partial word is discarded.
- In DONE, rx_valid with data is ignored; a new start reloads from addr 0, and done/overflow clear on the start cycle.
